// File: rtl/pwm_regs_pkg.sv
// Register map, channel block geometry and bit positions shared by the PWM
// register file and its per-channel slices.
package pwm_regs_pkg;

    localparam int unsigned CH_BASE   = 16;
    localparam int unsigned CH_STRIDE = 8;

    typedef enum logic [2:0] {
        REG_PERIOD_L = 3'd0,
        REG_PERIOD_H = 3'd1,
        REG_CTRL     = 3'd2,
        REG_PRESCALE = 3'd3,
        REG_CNT_L    = 3'd4,
        REG_CNT_H    = 3'd5,
        REG_STATUS   = 3'd6,
        REG_IRQ_EN   = 3'd7
    } glb_reg_e;

    typedef enum logic [2:0] {
        CHR_CMP1_L = 3'd0,
        CHR_CMP1_H = 3'd1,
        CHR_CMP2_L = 3'd2,
        CHR_CMP2_H = 3'd3,
        CHR_FUNC   = 3'd4,
        CHR_CH_EN  = 3'd5
    } ch_reg_e;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_UPND_BIT = 1;
    localparam int unsigned CTRL_CRST_BIT = 2;

    localparam int unsigned STAT_WRAP_BIT = 0;
    localparam int unsigned STAT_UPD_BIT  = 1;

    // Sticky status flag: a set on the same edge as a write-1-clear wins.
    function automatic logic w1c_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/pwm_chan_regs.sv
// One PWM channel's registers: byte stage, shadow and active copies of
// CMP1/CMP2/FUNC/CH_EN, plus its slice of the read mux.
module pwm_chan_regs
    import pwm_regs_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             write,
    input  logic [2:0]       offset,
    input  logic [7:0]       data_write,
    input  logic             xfer,
    output logic             commit,
    output logic [7:0]       data_read,
    output logic [CNT_W-1:0] compare1,
    output logic [CNT_W-1:0] compare2,
    output logic [7:0]       functions,
    output logic             pwm_en
);

    logic             wr;
    ch_reg_e          reg_sel;
    logic [7:0]       cmp1_stage, cmp2_stage;
    logic [CNT_W-1:0] cmp1_sh, cmp2_sh, cmp1_sh_d, cmp2_sh_d;
    logic [7:0]       func_sh, func_sh_d;
    logic             en_sh, en_sh_d;

    assign wr      = write & sel;
    assign reg_sel = ch_reg_e'(offset);

    // The shadow next-state feeds the active copy too, so a commit landing on
    // the transfer edge is carried straight through.
    always_comb begin
        cmp1_sh_d = cmp1_sh;
        cmp2_sh_d = cmp2_sh;
        func_sh_d = func_sh;
        en_sh_d   = en_sh;
        commit    = 1'b0;
        if (wr) begin
            case (reg_sel)
                CHR_CMP1_H: begin
                    cmp1_sh_d = {data_write[CNT_W-9:0], cmp1_stage};
                    commit    = 1'b1;
                end
                CHR_CMP2_H: begin
                    cmp2_sh_d = {data_write[CNT_W-9:0], cmp2_stage};
                    commit    = 1'b1;
                end
                CHR_FUNC: begin
                    func_sh_d = data_write;
                    commit    = 1'b1;
                end
                CHR_CH_EN: begin
                    en_sh_d = data_write[0];
                    commit  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp1_stage <= '0;
            cmp2_stage <= '0;
            cmp1_sh    <= '0;
            cmp2_sh    <= '0;
            func_sh    <= '0;
            en_sh      <= 1'b0;
            compare1   <= '0;
            compare2   <= '0;
            functions  <= '0;
            pwm_en     <= 1'b0;
        end else begin
            if (wr && reg_sel == CHR_CMP1_L) cmp1_stage <= data_write;
            if (wr && reg_sel == CHR_CMP2_L) cmp2_stage <= data_write;
            cmp1_sh <= cmp1_sh_d;
            cmp2_sh <= cmp2_sh_d;
            func_sh <= func_sh_d;
            en_sh   <= en_sh_d;
            if (xfer) begin
                compare1  <= cmp1_sh_d;
                compare2  <= cmp2_sh_d;
                functions <= func_sh_d;
                pwm_en    <= en_sh_d;
            end
        end
    end

    always_comb begin
        data_read = '0;
        if (sel) begin
            case (reg_sel)
                CHR_CMP1_L: data_read = cmp1_stage;
                CHR_CMP1_H: data_read = 8'(cmp1_sh[CNT_W-1:8]);
                CHR_CMP2_L: data_read = cmp2_stage;
                CHR_CMP2_H: data_read = 8'(cmp2_sh[CNT_W-1:8]);
                CHR_FUNC:   data_read = func_sh;
                CHR_CH_EN:  data_read = {7'd0, en_sh};
                default:    data_read = '0;
            endcase
        end
    end

endmodule

// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register file: global timer registers, status/interrupt,
// and NCH channel slices, all double-buffered and swapped at counter wrap.
module pwm_regs_mc
    import pwm_regs_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 read,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [7:0]           data_write,
    output logic [7:0]           data_read,
    input  logic [CNT_W-1:0]     counter_val,
    input  logic                 counter_wrap,
    output logic [CNT_W-1:0]     period,
    output logic                 en,
    output logic                 count_reset,
    output logic                 upnotdown,
    output logic [7:0]           prescale,
    output logic [NCH-1:0]       pwm_en,
    output logic [8*NCH-1:0]     functions,
    output logic [CNT_W*NCH-1:0] compare1,
    output logic [CNT_W*NCH-1:0] compare2,
    output logic                 irq
);

    logic [ADDR_W-4:0] blk;
    logic              glb_sel, wr_glb;
    glb_reg_e          greg;

    logic [7:0]        period_stage;
    logic [CNT_W-1:0]  period_sh, period_sh_d;
    logic [7:0]        presc_sh, presc_sh_d;
    logic              glb_commit, commit_any, pending, xfer;
    logic [CNT_W-9:0]  cnt_snap;
    logic [1:0]        status, status_d, irq_en;
    logic              stat_clr_wr;

    logic [NCH-1:0]    ch_sel, ch_commit;
    logic [7:0]        ch_rdata [NCH];

    assign blk     = addr[ADDR_W-1:3];
    assign glb_sel = (blk == '0);
    assign greg    = glb_reg_e'(addr[2:0]);
    assign wr_glb  = write & glb_sel;

    always_comb begin
        period_sh_d = period_sh;
        presc_sh_d  = presc_sh;
        glb_commit  = 1'b0;
        if (wr_glb) begin
            case (greg)
                REG_PERIOD_H: begin
                    period_sh_d = {data_write[CNT_W-9:0], period_stage};
                    glb_commit  = 1'b1;
                end
                REG_PRESCALE: begin
                    presc_sh_d = data_write;
                    glb_commit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Transfer at wrap (including a commit on that very edge), or on the edge
    // after a commit while the counter is stopped.
    assign commit_any = glb_commit | (|ch_commit);
    assign xfer       = (counter_wrap & (pending | commit_any)) | (~en & pending);

    assign stat_clr_wr = wr_glb && (greg == REG_STATUS);
    always_comb begin
        status_d                = status;
        status_d[STAT_WRAP_BIT] = w1c_next(status[STAT_WRAP_BIT], counter_wrap,
                                           stat_clr_wr & data_write[STAT_WRAP_BIT]);
        status_d[STAT_UPD_BIT]  = w1c_next(status[STAT_UPD_BIT], xfer,
                                           stat_clr_wr & data_write[STAT_UPD_BIT]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_stage <= '0;
            period_sh    <= '0;
            period       <= '0;
            presc_sh     <= '0;
            prescale     <= '0;
            en           <= 1'b0;
            upnotdown    <= 1'b0;
            count_reset  <= 1'b0;
            pending      <= 1'b0;
            cnt_snap     <= '0;
            status       <= '0;
            irq_en       <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_glb && greg == REG_PERIOD_L) period_stage <= data_write;
            period_sh <= period_sh_d;
            presc_sh  <= presc_sh_d;
            if (xfer) begin
                period   <= period_sh_d;
                prescale <= presc_sh_d;
            end
            pending <= xfer ? 1'b0 : (pending | commit_any);

            count_reset <= wr_glb && (greg == REG_CTRL) && data_write[CTRL_CRST_BIT];
            if (wr_glb && greg == REG_CTRL) begin
                en        <= data_write[CTRL_EN_BIT];
                upnotdown <= data_write[CTRL_UPND_BIT];
            end
            if (wr_glb && greg == REG_IRQ_EN) irq_en <= data_write[1:0];

            if (read && glb_sel && greg == REG_CNT_L) cnt_snap <= counter_val[CNT_W-1:8];

            status <= status_d;
            irq    <= |(status & irq_en);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam int unsigned BLK = (CH_BASE + c * CH_STRIDE) >> 3;
        assign ch_sel[c] = (blk == (ADDR_W-3)'(BLK));

        pwm_chan_regs #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .sel        (ch_sel[c]),
            .write      (write),
            .offset     (addr[2:0]),
            .data_write (data_write),
            .xfer       (xfer),
            .commit     (ch_commit[c]),
            .data_read  (ch_rdata[c]),
            .compare1   (compare1[c*CNT_W +: CNT_W]),
            .compare2   (compare2[c*CNT_W +: CNT_W]),
            .functions  (functions[c*8 +: 8]),
            .pwm_en     (pwm_en[c])
        );
    end

    always_comb begin
        data_read = '0;
        if (read) begin
            if (glb_sel) begin
                case (greg)
                    REG_PERIOD_L: data_read = period_stage;
                    REG_PERIOD_H: data_read = 8'(period_sh[CNT_W-1:8]);
                    REG_CTRL:     data_read = {6'd0, upnotdown, en};
                    REG_PRESCALE: data_read = presc_sh;
                    REG_CNT_L:    data_read = counter_val[7:0];
                    REG_CNT_H:    data_read = 8'(cnt_snap);
                    REG_STATUS:   data_read = {6'd0, status};
                    REG_IRQ_EN:   data_read = {6'd0, irq_en};
                    default:      data_read = '0;
                endcase
            end
            for (int unsigned i = 0; i < NCH; i++) data_read = data_read | ch_rdata[i];
        end
    end

endmodule
